// File: rtl/sb_pkg.sv
// Shared types and constants for the UCIe sideband transmit front-end.
// Holds LTSM state/sub-state encodings, per-state message numbers, sideband
// opcodes, the SBINIT clock pattern, the header word layout and a helper
// that assembles a header word with its parity bits.
package sb_pkg;

   typedef enum logic [2:0] {
      LtReset, LtSbinit, LtMbinit, LtMbtrain, LtLinkinit, LtActive, LtPhyretrain, LtTrainerror
   } ltsm_state_e;

   typedef enum logic [3:0] {
      SubParam, SubCal, SubRepairclk, SubRepairval, SubReversalmb, SubRepairmb
   } mbinit_sub_e;

   typedef enum logic [3:0] {
      SbinitDoneReq = 4'd1, SbinitDoneResp = 4'd2, SbinitOutOfReset = 4'd3
   } sbinit_msg_e;

   typedef enum logic [3:0] {
      MbinitReq = 4'd1, MbinitResp = 4'd2
   } mbinit_msg_e;

   typedef enum logic [2:0] {
      StIdle, StPattern, StPatternTail, StHeader, StData, StWaitRsp
   } tx_state_e;

   localparam logic [4:0]  OpMsgNoData = 5'b10010;
   localparam logic [4:0]  OpMsgData   = 5'b11011;
   localparam logic [63:0] ClkPattern  = 64'hAAAA_AAAA_AAAA_AAAA;

   typedef struct packed {
      logic        dp;
      logic        cp;
      logic [2:0]  rsvd_61_59;
      logic [2:0]  dstid;
      logic [7:0]  msgsubcode;
      logic [15:0] msginfo;
      logic [1:0]  rsvd_31_30;
      logic [2:0]  srcid;
      logic [4:0]  rsvd_26_22;
      logic [7:0]  msgcode;
      logic [8:0]  rsvd_13_5;
      logic [4:0]  opcode;
   } sb_hdr_t;

   // CP covers bits [61:0]; DP is the parity of the data word (0 when none).
   function automatic logic [63:0] build_hdr(input logic        with_data,
                                             input logic [7:0]  msgcode,
                                             input logic [7:0]  subcode,
                                             input logic [15:0] info,
                                             input logic [2:0]  srcid,
                                             input logic [2:0]  dstid,
                                             input logic        dp);
      sb_hdr_t     h;
      logic [63:0] w;
      h            = '0;
      h.opcode     = with_data ? OpMsgData : OpMsgNoData;
      h.msgcode    = msgcode;
      h.srcid      = srcid;
      h.msginfo    = info;
      h.msgsubcode = subcode;
      h.dstid      = dstid;
      w            = h;
      h.cp         = ^w[61:0];
      h.dp         = with_data & dp;
      return h;
   endfunction

endpackage

// File: rtl/sb_msg_encoder.sv
// Combinational message lookup: LTSM state/sub-state/msg_no or RDI fields ->
// msgcode, subcode, has_data, is_req, valid. An RDI request overrides the table.
// Optional feature macro: SB_TX_POINT_SWEEP_EN (MBTRAIN point/sweep test request).
// Ports: i_state, i_sub_state, i_msg_no, i_rdi_msg, i_rdi_msg_code, i_rdi_msg_sub_code,
//        i_tx_point_sweep_test_en, i_tx_point_sweep_test in; o_msgcode, o_subcode,
//        o_has_data, o_is_req, o_valid out.
module sb_msg_encoder
   import sb_pkg::*;
(
   input  logic [2:0] i_state,
   input  logic [3:0] i_sub_state,
   input  logic [3:0] i_msg_no,
   input  logic       i_rdi_msg,
   input  logic [1:0] i_rdi_msg_code,
   input  logic [3:0] i_rdi_msg_sub_code,
   input  logic       i_tx_point_sweep_test_en,
   input  logic [1:0] i_tx_point_sweep_test,
   output logic [7:0] o_msgcode,
   output logic [7:0] o_subcode,
   output logic       o_has_data,
   output logic       o_is_req,
   output logic       o_valid
);

   logic [3:0] half_up;
   logic [3:0] half_dn;

   assign half_up = (i_msg_no + 4'd1) >> 1;
   assign half_dn = i_msg_no >> 1;

`ifndef SB_TX_POINT_SWEEP_EN
   logic unused_pt;
   assign unused_pt = ^{i_tx_point_sweep_test_en, i_tx_point_sweep_test};
`endif

   always_comb begin
      o_msgcode  = 8'h00;
      o_subcode  = 8'h00;
      o_has_data = 1'b0;
      o_is_req   = 1'b0;
      o_valid    = 1'b0;
      if (i_rdi_msg) begin
         o_valid   = 1'b1;
         o_msgcode = {6'b000001, i_rdi_msg_code};
         o_subcode = {4'h0, i_rdi_msg_sub_code};
      end else begin
         case (i_state)
            LtSbinit: begin
               case (i_msg_no)
                  SbinitOutOfReset: begin
                     o_valid = 1'b1; o_msgcode = 8'h91; o_subcode = 8'h00;
                  end
                  SbinitDoneReq: begin
                     o_valid = 1'b1; o_msgcode = 8'h95; o_subcode = 8'h01; o_is_req = 1'b1;
                  end
                  SbinitDoneResp: begin
                     o_valid = 1'b1; o_msgcode = 8'h9A; o_subcode = 8'h01;
                  end
                  default: ;
               endcase
            end
            LtMbinit: begin
               case (i_sub_state)
                  SubParam, SubCal: begin
                     // PARAM carries a config data word; CAL uses subcode 02.
                     o_has_data = (i_sub_state == SubParam);
                     o_subcode  = (i_sub_state == SubParam) ? 8'h00 : 8'h02;
                     if (i_msg_no == MbinitReq) begin
                        o_valid = 1'b1; o_msgcode = 8'hA5; o_is_req = 1'b1;
                     end else if (i_msg_no == MbinitResp) begin
                        o_valid = 1'b1; o_msgcode = 8'hAA;
                     end
                  end
                  SubRepairclk: begin
                     if (i_msg_no >= 4'd1 && i_msg_no <= 4'd6) begin
                        o_valid = 1'b1;
                        if (i_msg_no[0]) begin
                           o_msgcode = 8'hA5;
                           o_subcode = 8'h02 + {4'h0, half_up};
                           o_is_req  = 1'b1;
                        end else begin
                           o_msgcode = 8'hAA;
                           o_subcode = 8'h02 + {4'h0, half_dn};
                        end
                     end
                  end
                  default: ;
               endcase
            end
`ifdef SB_TX_POINT_SWEEP_EN
            LtMbtrain: begin
               if (i_tx_point_sweep_test_en) begin
                  o_valid   = 1'b1;
                  o_msgcode = 8'h85;
                  o_subcode = 8'h01 + {6'h00, i_tx_point_sweep_test};
                  o_is_req  = 1'b1;
               end
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/sb_tx_wrapper.sv
// UCIe sideband transmit front-end. Sends the SBINIT clock pattern (with a
// tail of PATTERN_EXTRA words after partner detection and a timeout), encodes
// LTSM/RDI requests into header (+ optional data) words, and waits for the
// response to request messages. A word advances on each i_ser_done.
// Optional feature macro: SB_TX_POINT_SWEEP_EN (see sb_msg_encoder).
// Ports: i_clk, i_rst (sync, active-high); pattern control i_start_pattern_req,
//        i_rx_sb_pattern_samp_done; LTSM msg i_msg_*, i_data_*, i_state, i_sub_state;
//        RDI i_rdi_*; point/sweep i_tx_point_sweep_*; i_rx_sb_rsp_delivered,
//        i_ser_done, i_stop_cnt; outputs o_start_pattern_done, o_time_out,
//        o_tx_data_out, o_busy.
module sb_tx_wrapper
   import sb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 800,
   parameter int unsigned PATTERN_EXTRA  = 4,
   parameter logic [2:0]  SRCID          = 3'b010,
   parameter logic [2:0]  DSTID          = 3'b110
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start_pattern_req,
   input  logic        i_rx_sb_pattern_samp_done,
   input  logic        i_msg_valid,
   input  logic [3:0]  i_msg_no,
   input  logic [2:0]  i_msg_info,
   input  logic        i_data_valid,
   input  logic [15:0] i_data_bus,
   input  logic [2:0]  i_state,
   input  logic [3:0]  i_sub_state,
   input  logic        i_rdi_msg,
   input  logic [1:0]  i_rdi_msg_code,
   input  logic [3:0]  i_rdi_msg_sub_code,
   input  logic [1:0]  i_rdi_msg_info,
   input  logic        i_tx_point_sweep_test_en,
   input  logic [1:0]  i_tx_point_sweep_test,
   input  logic        i_rx_sb_rsp_delivered,
   input  logic        i_ser_done,
   input  logic        i_stop_cnt,
   output logic        o_start_pattern_done,
   output logic        o_time_out,
   output logic [63:0] o_tx_data_out,
   output logic        o_busy
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned ExtW = (PATTERN_EXTRA > 0) ? $clog2(PATTERN_EXTRA + 1) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
   localparam logic [ExtW-1:0] ExtLast = ExtW'(PATTERN_EXTRA);

   tx_state_e       state_q, state_d;
   logic [63:0]     data_out_q, data_out_d;
   logic [CntW-1:0] to_cnt_q, to_cnt_d;
   logic [ExtW-1:0] ext_cnt_q, ext_cnt_d;
   logic            pat_done_q, pat_done_d;
   logic            time_out_q, time_out_d;
   logic            msg_valid_q, msg_valid_d;
   logic [3:0]      msg_no_q, msg_no_d;
   logic            rdi_q, rdi_d;
   logic            with_data_q, with_data_d;
   logic            is_req_q, is_req_d;
   logic [15:0]     data_word_q, data_word_d;

   logic [7:0]  enc_msgcode, enc_subcode;
   logic        enc_has_data, enc_is_req, enc_valid;
   logic        req_new, with_data_new;
   logic [15:0] info_new;
   logic [63:0] hdr_word;

   sb_msg_encoder u_enc (
      .i_state                  (i_state),
      .i_sub_state              (i_sub_state),
      .i_msg_no                 (i_msg_no),
      .i_rdi_msg                (i_rdi_msg),
      .i_rdi_msg_code           (i_rdi_msg_code),
      .i_rdi_msg_sub_code       (i_rdi_msg_sub_code),
      .i_tx_point_sweep_test_en (i_tx_point_sweep_test_en),
      .i_tx_point_sweep_test    (i_tx_point_sweep_test),
      .o_msgcode                (enc_msgcode),
      .o_subcode                (enc_subcode),
      .o_has_data               (enc_has_data),
      .o_is_req                 (enc_is_req),
      .o_valid                  (enc_valid)
   );

   // New request: RDI rising edge, or LTSM valid rising / msg_no change while
   // no RDI request is present (RDI wins when both are high).
   assign req_new = (i_rdi_msg & ~rdi_q) |
                    (~i_rdi_msg & i_msg_valid & (~msg_valid_q | (i_msg_no != msg_no_q)));
   assign with_data_new = ~i_rdi_msg & (enc_has_data | i_data_valid);
   assign info_new = i_rdi_msg ? {14'h0, i_rdi_msg_info} : {13'h0, i_msg_info};
   assign hdr_word = build_hdr(with_data_new, enc_msgcode, enc_subcode, info_new,
                               SRCID, DSTID, ^i_data_bus);

   always_comb begin
      state_d     = state_q;
      data_out_d  = data_out_q;
      to_cnt_d    = '0;
      ext_cnt_d   = ext_cnt_q;
      pat_done_d  = 1'b0;
      time_out_d  = 1'b0;
      msg_valid_d = i_msg_valid;
      msg_no_d    = i_msg_no;
      rdi_d       = i_rdi_msg;
      with_data_d = with_data_q;
      is_req_d    = is_req_q;
      data_word_d = data_word_q;
      unique case (state_q)
         StIdle: begin
            data_out_d = '0;
            if (i_start_pattern_req) begin
               state_d    = StPattern;
               data_out_d = ClkPattern;
            end else if (req_new && enc_valid) begin
               state_d     = StHeader;
               data_out_d  = hdr_word;
               with_data_d = with_data_new;
               is_req_d    = ~i_rdi_msg & enc_is_req;
               data_word_d = i_data_bus;
            end
         end
         StPattern: begin
            if (i_ser_done) data_out_d = ClkPattern;
            if (i_rx_sb_pattern_samp_done) begin
               state_d   = StPatternTail;
               ext_cnt_d = '0;
            end else if (i_stop_cnt) begin
               to_cnt_d = '0;
            end else if (to_cnt_q == CntLast) begin
               time_out_d = 1'b1;
               state_d    = StIdle;
               data_out_d = '0;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         StPatternTail: begin
            if (i_ser_done) begin
               if (ext_cnt_q == ExtLast) begin
                  pat_done_d = 1'b1;
                  state_d    = StIdle;
                  data_out_d = '0;
               end else begin
                  ext_cnt_d  = ext_cnt_q + 1'b1;
                  data_out_d = ClkPattern;
               end
            end
         end
         StHeader, StData: begin
            if (i_ser_done) begin
               if (state_q == StHeader && with_data_q) begin
                  state_d    = StData;
                  data_out_d = {48'h0, data_word_q};
               end else if (is_req_q) begin
                  state_d = StWaitRsp;
               end else begin
                  state_d    = StIdle;
                  data_out_d = '0;
               end
            end
         end
         StWaitRsp: begin
            if (i_rx_sb_rsp_delivered) begin
               state_d    = StIdle;
               data_out_d = '0;
            end else if (i_stop_cnt) begin
               to_cnt_d = '0;
            end else if (to_cnt_q == CntLast) begin
               time_out_d = 1'b1;
               state_d    = StIdle;
               data_out_d = '0;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d    = StIdle;
            data_out_d = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= StIdle;
         data_out_q  <= '0;
         to_cnt_q    <= '0;
         ext_cnt_q   <= '0;
         pat_done_q  <= 1'b0;
         time_out_q  <= 1'b0;
         msg_valid_q <= 1'b0;
         msg_no_q    <= '0;
         rdi_q       <= 1'b0;
         with_data_q <= 1'b0;
         is_req_q    <= 1'b0;
         data_word_q <= '0;
      end else begin
         state_q     <= state_d;
         data_out_q  <= data_out_d;
         to_cnt_q    <= to_cnt_d;
         ext_cnt_q   <= ext_cnt_d;
         pat_done_q  <= pat_done_d;
         time_out_q  <= time_out_d;
         msg_valid_q <= msg_valid_d;
         msg_no_q    <= msg_no_d;
         rdi_q       <= rdi_d;
         with_data_q <= with_data_d;
         is_req_q    <= is_req_d;
         data_word_q <= data_word_d;
      end
   end

   assign o_tx_data_out        = data_out_q;
   assign o_busy               = (state_q != StIdle);
   assign o_start_pattern_done = pat_done_q;
   assign o_time_out           = time_out_q;

endmodule

// File: tb/tb_sb_tx_wrapper.sv
// Directed bench for sb_tx_wrapper. Expected message words are pushed to a
// queue when a request is driven; a negedge monitor pops and compares each new
// non-pattern word the DUT presents.
module tb_sb_tx_wrapper;

   localparam int unsigned TO  = 800;
   localparam int unsigned PE  = 4;
   localparam logic [63:0] PAT = 64'hAAAA_AAAA_AAAA_AAAA;

   logic        i_clk, i_rst;
   logic        i_start_pattern_req, i_rx_sb_pattern_samp_done;
   logic        i_msg_valid;
   logic [3:0]  i_msg_no;
   logic [2:0]  i_msg_info;
   logic        i_data_valid;
   logic [15:0] i_data_bus;
   logic [2:0]  i_state;
   logic [3:0]  i_sub_state;
   logic        i_rdi_msg;
   logic [1:0]  i_rdi_msg_code;
   logic [3:0]  i_rdi_msg_sub_code;
   logic [1:0]  i_rdi_msg_info;
   logic        i_tx_point_sweep_test_en;
   logic [1:0]  i_tx_point_sweep_test;
   logic        i_rx_sb_rsp_delivered, i_ser_done, i_stop_cnt;
   logic        o_start_pattern_done, o_time_out, o_busy;
   logic [63:0] o_tx_data_out;

   int          tests = 0;
   int          fails = 0;
   logic [63:0] sb[$];
   logic [63:0] last_seen = '0;

   sb_tx_wrapper #(
      .TIMEOUT_CYCLES (TO),
      .PATTERN_EXTRA  (PE),
      .SRCID          (3'b010),
      .DSTID          (3'b110)
   ) dut (
      .i_clk                     (i_clk),
      .i_rst                     (i_rst),
      .i_start_pattern_req       (i_start_pattern_req),
      .i_rx_sb_pattern_samp_done (i_rx_sb_pattern_samp_done),
      .i_msg_valid               (i_msg_valid),
      .i_msg_no                  (i_msg_no),
      .i_msg_info                (i_msg_info),
      .i_data_valid              (i_data_valid),
      .i_data_bus                (i_data_bus),
      .i_state                   (i_state),
      .i_sub_state               (i_sub_state),
      .i_rdi_msg                 (i_rdi_msg),
      .i_rdi_msg_code            (i_rdi_msg_code),
      .i_rdi_msg_sub_code        (i_rdi_msg_sub_code),
      .i_rdi_msg_info            (i_rdi_msg_info),
      .i_tx_point_sweep_test_en  (i_tx_point_sweep_test_en),
      .i_tx_point_sweep_test     (i_tx_point_sweep_test),
      .i_rx_sb_rsp_delivered     (i_rx_sb_rsp_delivered),
      .i_ser_done                (i_ser_done),
      .i_stop_cnt                (i_stop_cnt),
      .o_start_pattern_done      (o_start_pattern_done),
      .o_time_out                (o_time_out),
      .o_tx_data_out             (o_tx_data_out),
      .o_busy                    (o_busy)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Header model built field by field from the word layout.
   function automatic logic [63:0] exp_hdr(input logic [7:0] mc, input logic [7:0] sc,
                                           input logic [15:0] info, input logic dat,
                                           input logic [15:0] d);
      logic [63:0] w;
      w        = 64'h0;
      w[4:0]   = dat ? 5'b11011 : 5'b10010;
      w[21:14] = mc;
      w[29:27] = 3'b010;
      w[47:32] = info;
      w[55:48] = sc;
      w[58:56] = 3'b110;
      w[62]    = ^w[61:0];
      w[63]    = dat ? ^d : 1'b0;
      return w;
   endfunction

   // Scoreboard monitor: each new message word must match the queue head.
   always @(negedge i_clk) begin
      if (!i_rst) begin
         if (o_tx_data_out == 64'h0) begin
            last_seen = 64'h0;
         end else if (o_tx_data_out != PAT && o_tx_data_out != last_seen) begin
            last_seen = o_tx_data_out;
            check("sb_word_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) check("sb_word", o_tx_data_out, sb.pop_front());
         end
      end
   end

   initial begin
      int   n;
      int   words;
      logic seen;
      logic to_seen;

      i_rst = 1'b1;
      i_start_pattern_req = 0; i_rx_sb_pattern_samp_done = 0;
      i_msg_valid = 0; i_msg_no = 0; i_msg_info = 0; i_data_valid = 0; i_data_bus = 0;
      i_state = 0; i_sub_state = 0;
      i_rdi_msg = 0; i_rdi_msg_code = 0; i_rdi_msg_sub_code = 0; i_rdi_msg_info = 0;
      i_tx_point_sweep_test_en = 0; i_tx_point_sweep_test = 0;
      i_rx_sb_rsp_delivered = 0; i_ser_done = 1; i_stop_cnt = 0;

      // Reset state
      repeat (5) tick();
      check("rst_data", o_tx_data_out, 64'h0);
      check("rst_busy", 64'(o_busy), 64'd0);
      check("rst_done", 64'(o_start_pattern_done), 64'd0);
      check("rst_timeout", 64'(o_time_out), 64'd0);
      i_rst = 1'b0;
      tick();

      // Pattern with no partner detection -> timeout
      i_start_pattern_req = 1; tick(); i_start_pattern_req = 0;
      check("pat_word", o_tx_data_out, PAT);
      check("pat_busy", 64'(o_busy), 64'd1);
      n = 0; seen = 0;
      for (int i = 0; i < 2000; i++) begin
         tick(); n++;
         if (o_time_out) begin seen = 1; break; end
      end
      check("pat_timeout_seen", 64'(seen), 64'd1);
      check("pat_timeout_cycle", 64'(n), 64'(TO));
      check("pat_timeout_busy", 64'(o_busy), 64'd0);
      tick();

      // Pattern with detection at cycle 100 -> PE tail words, done pulse
      i_start_pattern_req = 1; tick(); i_start_pattern_req = 0;
      repeat (99) tick();
      i_rx_sb_pattern_samp_done = 1; tick(); i_rx_sb_pattern_samp_done = 0;
      n = 0; words = 0; seen = 0; to_seen = 0;
      for (int i = 0; i < 50; i++) begin
         tick(); n++;
         if (o_time_out) to_seen = 1;
         if (o_start_pattern_done) begin seen = 1; break; end
         if (o_busy && o_tx_data_out === PAT) words++;
      end
      check("tail_done_seen", 64'(seen), 64'd1);
      check("tail_words", 64'(words), 64'(PE));
      check("tail_done_cycle", 64'(n), 64'(PE + 1));
      check("tail_no_timeout", 64'(to_seen), 64'd0);
      check("tail_idle_busy", 64'(o_busy), 64'd0);
      check("tail_idle_data", o_tx_data_out, 64'h0);
      tick();

      // SBINIT: msg_no 3 -> 1 -> 2 with valid held high
      i_state = 3'd1; i_msg_info = 3'b101; i_msg_valid = 1; i_msg_no = 4'd3;
      sb.push_back(exp_hdr(8'h91, 8'h00, 16'h0005, 1'b0, 16'h0));
      tick(); repeat (7) tick();
      check("sbinit_oor_idle", 64'(o_busy), 64'd0);
      i_msg_no = 4'd1;
      sb.push_back(exp_hdr(8'h95, 8'h01, 16'h0005, 1'b0, 16'h0));
      tick(); repeat (7) tick();
      check("sbinit_req_wait_busy", 64'(o_busy), 64'd1);
      i_rx_sb_rsp_delivered = 1; tick(); i_rx_sb_rsp_delivered = 0;
      check("sbinit_rsp_busy", 64'(o_busy), 64'd0);
      i_msg_no = 4'd2;
      sb.push_back(exp_hdr(8'h9A, 8'h01, 16'h0005, 1'b0, 16'h0));
      tick(); repeat (7) tick();
      check("sbinit_no_resend", 64'(sb.size()), 64'd0);
      i_msg_valid = 0; tick();

      // MBINIT PARAM config request with data
      i_state = 3'd2; i_sub_state = 4'd0; i_msg_no = 4'd1; i_msg_info = 3'b011;
      i_data_valid = 1; i_data_bus = 16'h3524; i_msg_valid = 1;
      sb.push_back(exp_hdr(8'hA5, 8'h00, 16'h0003, 1'b1, 16'h3524));
      sb.push_back(64'h0000_0000_0000_3524);
      tick(); repeat (4) tick();
      check("param_wait_busy", 64'(o_busy), 64'd1);
      i_rx_sb_rsp_delivered = 1; tick(); i_rx_sb_rsp_delivered = 0;
      i_msg_valid = 0; i_data_valid = 0; tick();

      // REPAIRCLK request, response delivered
      i_sub_state = 4'd2; i_msg_no = 4'd1; i_msg_info = 3'b000; i_msg_valid = 1;
      sb.push_back(exp_hdr(8'hA5, 8'h03, 16'h0000, 1'b0, 16'h0));
      tick(); repeat (3) tick();
      check("rclk_wait_busy", 64'(o_busy), 64'd1);
      i_rx_sb_rsp_delivered = 1; tick(); i_rx_sb_rsp_delivered = 0;
      check("rclk_rsp_busy", 64'(o_busy), 64'd0);
      i_msg_valid = 0; tick();

      // REPAIRCLK request again, no response -> timeout
      i_msg_valid = 1;
      sb.push_back(exp_hdr(8'hA5, 8'h03, 16'h0000, 1'b0, 16'h0));
      tick();
      n = 0; seen = 0;
      for (int i = 0; i < 2000; i++) begin
         tick(); n++;
         if (o_time_out) begin seen = 1; break; end
      end
      check("rsp_timeout_seen", 64'(seen), 64'd1);
      check("rsp_timeout_cycle", 64'(n), 64'(TO + 1));
      check("rsp_timeout_busy", 64'(o_busy), 64'd0);
      i_msg_valid = 0; tick();

      // REPAIRCLK response n=4 -> {AA,04}, no wait
      i_msg_no = 4'd4; i_msg_valid = 1;
      sb.push_back(exp_hdr(8'hAA, 8'h04, 16'h0000, 1'b0, 16'h0));
      tick(); repeat (3) tick();
      check("rclk_resp_idle", 64'(o_busy), 64'd0);
      i_msg_valid = 0; tick();

      // RDI and LTSM request together: RDI wins
      i_rdi_msg = 1; i_rdi_msg_code = 2'b10; i_rdi_msg_sub_code = 4'h3; i_rdi_msg_info = 2'b01;
      i_msg_no = 4'd1; i_msg_valid = 1;
      sb.push_back(exp_hdr(8'h06, 8'h03, 16'h0001, 1'b0, 16'h0));
      tick(); repeat (4) tick();
      check("rdi_idle", 64'(o_busy), 64'd0);
      i_rdi_msg = 0; i_msg_valid = 0; tick();

      // Unlisted combination: nothing sent
      i_state = 3'd5; i_msg_no = 4'd1; i_msg_valid = 1;
      tick();
      check("unlisted_busy", 64'(o_busy), 64'd0);
      check("unlisted_data", o_tx_data_out, 64'h0);
      i_msg_valid = 0; tick();

      // Reset in the middle of the pattern phase
      i_start_pattern_req = 1; tick(); i_start_pattern_req = 0;
      repeat (10) tick();
      check("midrst_pre_busy", 64'(o_busy), 64'd1);
      i_rst = 1; tick();
      check("midrst_data", o_tx_data_out, 64'h0);
      check("midrst_busy", 64'(o_busy), 64'd0);
      check("midrst_done", 64'(o_start_pattern_done), 64'd0);
      check("midrst_timeout", 64'(o_time_out), 64'd0);
      i_rst = 0; repeat (2) tick();

      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
